// File: rtl/sigstream_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sigstream_pkg
// Brief   : Shared defaults and FSM encoding for the sigstream/sigsource family.
// Revision: 1.0 - initial release
// ============================================================================
package sigstream_pkg;

    localparam int c_width = 32;   // antennas per sample
    localparam int c_trate = 30;   // replays per antenna sample
    localparam int c_tbits = 5;    // time-slot address width
    localparam int c_count = 64;   // antenna samples per correlation window
    localparam int c_cbits = 6;    // window-counter width

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_play = 1'b1;

endpackage : sigstream_pkg
`default_nettype wire

// File: rtl/sigstream_if.sv
`default_nettype none
// ============================================================================
// Module  : sigstream_if
// Brief   : Sample-in / replay-stream-out bundle for sigstream.
// Revision: 1.0 - initial release
// ============================================================================
interface sigstream_if
    import sigstream_pkg::*;
#(
    parameter int WIDTH = c_width,
    parameter int TBITS = c_tbits
);
    logic             strobe_i;
    logic [WIDTH-1:0] idata_i;
    logic [WIDTH-1:0] qdata_i;
    logic             valid_o;
    logic             first_o;
    logic             last_o;
    logic [TBITS-1:0] taddr_o;
    logic [WIDTH-1:0] idata_o;
    logic [WIDTH-1:0] qdata_o;
    logic             overflow_o;

    modport master (
        output strobe_i, idata_i, qdata_i,
        input  valid_o, first_o, last_o, taddr_o, idata_o, qdata_o, overflow_o
    );

    modport slave (
        input  strobe_i, idata_i, qdata_i,
        output valid_o, first_o, last_o, taddr_o, idata_o, qdata_o, overflow_o
    );

endinterface : sigstream_if
`default_nettype wire

// File: rtl/sigstream_tcounter.sv
`default_nettype none
// ============================================================================
// Module  : tcounter
// Brief   : Time-slot / window counter pair with look-ahead window markers.
// Revision: 1.0 - initial release
// ============================================================================
module tcounter
    import sigstream_pkg::*;
#(
    parameter int TRATE = c_trate,
    parameter int TBITS = c_tbits,
    parameter int COUNT = c_count,
    parameter int CBITS = c_cbits
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en_i,
    output logic [TBITS-1:0] taddr_o,
    output logic             wrap_o,
    output logic             start_o,
    output logic             term_o
);

    localparam logic [TBITS-1:0] c_tlast = TBITS'(TRATE - 1);
    localparam logic [CBITS-1:0] c_slast = CBITS'(COUNT - 1);

    logic [TBITS-1:0] taddr_q, taddr_d;
    logic [CBITS-1:0] scnt_q, scnt_d;

    always_comb begin
        taddr_d = taddr_q;
        scnt_d  = scnt_q;
        if (en_i) begin
            if (taddr_q == c_tlast) begin
                taddr_d = '0;
                scnt_d  = (scnt_q == c_slast) ? '0 : scnt_q + 1'b1;
            end else begin
                taddr_d = taddr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            taddr_q <= '0;
            scnt_q  <= '0;
        end else begin
            taddr_q <= taddr_d;
            scnt_q  <= scnt_d;
        end
    end

    // start/term describe the beat about to be registered so first/last can be flopped.
    assign taddr_o = taddr_q;
    assign wrap_o  = (taddr_q == c_tlast);
    assign start_o = (taddr_d == '0) && (scnt_d == '0);
    assign term_o  = (taddr_d == c_tlast) && (scnt_d == c_slast);

endmodule : tcounter
`default_nettype wire

// File: rtl/sigstream.sv
`default_nettype none
// ============================================================================
// Module  : sigstream
// Brief   : Replays each strobed I/Q antenna sample TRATE times as a stream.
// Revision: 1.0 - initial release
// ============================================================================
module sigstream
    import sigstream_pkg::*;
#(
    parameter int WIDTH = c_width,
    parameter int TRATE = c_trate,
    parameter int TBITS = c_tbits,
    parameter int COUNT = c_count,
    parameter int CBITS = c_cbits
) (
    input  logic       clock,
    input  logic       reset,
    sigstream_if.slave bus
);

    logic [0:0]       state_q, state_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] pend_i_q, pend_i_d, pend_q_q, pend_q_d;
    logic [WIDTH-1:0] act_i_q, act_i_d, act_q_q, act_q_d;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             ovf_q, ovf_d;

    logic [TBITS-1:0] w_taddr;
    logic             w_wrap, w_start, w_term;
    logic             w_load, w_capture;

    tcounter #(
        .TRATE (TRATE),
        .TBITS (TBITS),
        .COUNT (COUNT),
        .CBITS (CBITS)
    ) u_tcounter (
        .clock   (clock),
        .reset   (reset),
        .en_i    (state_q == c_st_play),
        .taddr_o (w_taddr),
        .wrap_o  (w_wrap),
        .start_o (w_start),
        .term_o  (w_term)
    );

    // Pending moves to active when idle, or back-to-back at the last time slot.
    assign w_load    = full_q && ((state_q == c_st_idle) || w_wrap);
    assign w_capture = bus.strobe_i && (!full_q || w_load);

    always_comb begin
        full_d   = full_q;
        pend_i_d = pend_i_q;
        pend_q_d = pend_q_q;
        act_i_d  = act_i_q;
        act_q_d  = act_q_q;
        ovf_d    = ovf_q;
        if (w_load) begin
            act_i_d = pend_i_q;
            act_q_d = pend_q_q;
            full_d  = 1'b0;
        end
        if (w_capture) begin
            pend_i_d = bus.idata_i;
            pend_q_d = bus.qdata_i;
            full_d   = 1'b1;
        end else if (bus.strobe_i) begin
            ovf_d = 1'b1;
        end
        valid_d = w_load || ((state_q == c_st_play) && !w_wrap);
        state_d = valid_d ? c_st_play : c_st_idle;
        first_d = valid_d && w_start;
        last_d  = valid_d && w_term;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= c_st_idle;
            full_q   <= 1'b0;
            pend_i_q <= '0;
            pend_q_q <= '0;
            act_i_q  <= '0;
            act_q_q  <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            full_q   <= full_d;
            pend_i_q <= pend_i_d;
            pend_q_q <= pend_q_d;
            act_i_q  <= act_i_d;
            act_q_q  <= act_q_d;
            valid_q  <= valid_d;
            first_q  <= first_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.first_o    = first_q;
    assign bus.last_o     = last_q;
    assign bus.taddr_o    = w_taddr;
    assign bus.idata_o    = act_i_q;
    assign bus.qdata_o    = act_q_q;
    assign bus.overflow_o = ovf_q;

endmodule : sigstream
`default_nettype wire

// File: tb/tb_sigstream.sv
`default_nettype none
// ============================================================================
// Module  : tb_sigstream
// Brief   : Scoreboard bench for sigstream (WIDTH=4, TRATE=3, COUNT=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_sigstream;

    localparam int WIDTH = 4;
    localparam int TRATE = 3;
    localparam int TBITS = 2;
    localparam int COUNT = 2;
    localparam int CBITS = 1;

    typedef struct packed {
        logic [TBITS-1:0] taddr;
        logic [WIDTH-1:0] idata;
        logic [WIDTH-1:0] qdata;
        logic             first;
        logic             last;
    } beat_t;

    logic  clock;
    logic  reset;
    beat_t exp_q[$];
    int    checks;
    int    failures;
    int    exp_scnt;

    sigstream_if #(.WIDTH(WIDTH), .TBITS(TBITS)) bus();

    sigstream #(
        .WIDTH (WIDTH),
        .TRATE (TRATE),
        .TBITS (TBITS),
        .COUNT (COUNT),
        .CBITS (CBITS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected beats of one replayed sample; window position tracked independently.
    task automatic push_sample(input logic [WIDTH-1:0] i, input logic [WIDTH-1:0] q);
        for (int t = 0; t < TRATE; t++) begin
            beat_t b;
            b.taddr = TBITS'(t);
            b.idata = i;
            b.qdata = q;
            b.first = (t == 0) && (exp_scnt == 0);
            b.last  = (t == TRATE - 1) && (exp_scnt == COUNT - 1);
            exp_q.push_back(b);
        end
        exp_scnt = (exp_scnt + 1) % COUNT;
    endtask

    task automatic send(input logic [WIDTH-1:0] i, input logic [WIDTH-1:0] q, input bit replay);
        bus.strobe_i = 1'b1;
        bus.idata_i  = i;
        bus.qdata_i  = q;
        if (replay) push_sample(i, q);
        tick();
        bus.strobe_i = 1'b0;
    endtask

    task automatic monitor();
        beat_t got, want;
        forever begin
            @(negedge clock);
            if (!reset) begin
                checks++;
                if (bus.valid_o) begin
                    got = {bus.taddr_o, bus.idata_o, bus.qdata_o, bus.first_o, bus.last_o};
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_beat got taddr=%0d i=%h q=%h first=%b last=%b, want no beat",
                                 got.taddr, got.idata, got.qdata, got.first, got.last);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            failures++;
                            $display("FAIL beat got taddr=%0d i=%h q=%h first=%b last=%b, want taddr=%0d i=%h q=%h first=%b last=%b",
                                     got.taddr, got.idata, got.qdata, got.first, got.last,
                                     want.taddr, want.idata, want.qdata, want.first, want.last);
                        end
                    end
                end else if ((bus.first_o | bus.last_o) !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_flags got first=%b last=%b, want 0 0", bus.first_o, bus.last_o);
                end
            end
        end
    endtask

    task automatic do_reset();
        bus.strobe_i = 1'b0;
        reset        = 1'b1;
        exp_q.delete();
        exp_scnt     = 0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drained got %0d beats outstanding, want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        logic [13:0] snap;
        #2 reset = 1'b1;
        #1;
        snap = {bus.valid_o, bus.first_o, bus.last_o, bus.taddr_o, bus.idata_o, bus.qdata_o, bus.overflow_o};
        checks++;
        if (snap !== '0) begin
            failures++;
            $display("FAIL reset_outputs got %h, want 0", snap);
        end
        bus.strobe_i = 1'b1;
        bus.idata_i  = 4'hF;
        bus.qdata_i  = 4'hF;
        tick();
        tick();
        bus.strobe_i = 1'b0;
        reset        = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL strobe_in_reset got valid=%b, want 0", bus.valid_o);
        end
        checks++;
        if (bus.overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_overflow got %b, want 0", bus.overflow_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        send(4'hA, 4'h5, 1'b1);
        checks++;
        if (bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL single_latency_early got valid=%b, want 0", bus.valid_o);
        end
        tick();
        checks++;
        if ({bus.valid_o, bus.taddr_o, bus.first_o} !== {1'b1, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL single_first_beat got valid=%b taddr=%0d first=%b, want 1 0 1",
                     bus.valid_o, bus.taddr_o, bus.first_o);
        end
        repeat (3) tick();
        checks++;
        if (bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL single_tail got valid=%b, want 0", bus.valid_o);
        end
        check_drained("single");
    endtask

    task automatic test_stream();
        do_reset();
        for (int c = 0; c < 14; c++) begin
            if ((c % 3 == 0) && (c < 12)) begin
                logic [WIDTH-1:0] iv, qv;
                iv = WIDTH'(c / 3 + 3);
                qv = WIDTH'(12 - c / 3);
                send(iv, qv, 1'b1);
            end else begin
                tick();
            end
            if (c >= 1 && c <= 12) begin
                checks++;
                if (bus.valid_o !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_contiguous cycle %0d got valid=%b, want 1", c, bus.valid_o);
                end
            end
        end
        checks++;
        if (bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL stream_end got valid=%b, want 0", bus.valid_o);
        end
        checks++;
        if (bus.overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL stream_overflow got %b, want 0", bus.overflow_o);
        end
        check_drained("stream");
    endtask

    task automatic test_overflow();
        do_reset();
        send(4'h1, 4'hE, 1'b1);
        checks++;
        if (bus.overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_first got %b, want 0", bus.overflow_o);
        end
        send(4'h2, 4'hD, 1'b1);
        checks++;
        if (bus.overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_second got %b, want 0", bus.overflow_o);
        end
        send(4'h3, 4'hC, 1'b0);
        checks++;
        if (bus.overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_third got %b, want 1", bus.overflow_o);
        end
        repeat (8) tick();
        checks++;
        if ({bus.overflow_o, bus.valid_o} !== 2'b10) begin
            failures++;
            $display("FAIL ovf_sticky got overflow=%b valid=%b, want 1 0", bus.overflow_o, bus.valid_o);
        end
        check_drained("overflow");
    endtask

    task automatic test_boundary();
        do_reset();
        send(4'h6, 4'h9, 1'b1);
        repeat (3) tick();
        checks++;
        if ({bus.valid_o, bus.taddr_o} !== {1'b1, 2'd2}) begin
            failures++;
            $display("FAIL boundary_slot got valid=%b taddr=%0d, want 1 2", bus.valid_o, bus.taddr_o);
        end
        send(4'h7, 4'h8, 1'b1);
        checks++;
        if (bus.overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL boundary_overflow got %b, want 0", bus.overflow_o);
        end
        // New sample may start immediately or after a single idle cycle.
        if (!(bus.valid_o === 1'b1 && bus.idata_o === 4'h7)) tick();
        checks++;
        if ({bus.valid_o, bus.taddr_o, bus.idata_o} !== {1'b1, 2'd0, 4'h7}) begin
            failures++;
            $display("FAIL boundary_restart got valid=%b taddr=%0d i=%h, want 1 0 7",
                     bus.valid_o, bus.taddr_o, bus.idata_o);
        end
        repeat (4) tick();
        check_drained("boundary");
    endtask

    task automatic test_reset_mid();
        logic [13:0] snap;
        do_reset();
        send(4'h1, 4'h1, 1'b1);
        tick();
        tick();
        send(4'h2, 4'h2, 1'b1);
        tick();
        tick();
        checks++;
        if ({bus.valid_o, bus.taddr_o} !== {1'b1, 2'd1}) begin
            failures++;
            $display("FAIL midreset_beat4 got valid=%b taddr=%0d, want 1 1", bus.valid_o, bus.taddr_o);
        end
        #2 reset = 1'b1;
        exp_q.delete();
        exp_scnt = 0;
        #1;
        snap = {bus.valid_o, bus.first_o, bus.last_o, bus.taddr_o, bus.idata_o, bus.qdata_o, bus.overflow_o};
        checks++;
        if (snap !== '0) begin
            failures++;
            $display("FAIL midreset_async got %h, want 0", snap);
        end
        tick();
        reset = 1'b0;
        tick();
        send(4'h3, 4'h3, 1'b1);
        tick();
        checks++;
        if ({bus.valid_o, bus.taddr_o, bus.first_o} !== {1'b1, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL midreset_first got valid=%b taddr=%0d first=%b, want 1 0 1",
                     bus.valid_o, bus.taddr_o, bus.first_o);
        end
        repeat (3) tick();
        check_drained("midreset");
    endtask

    task automatic test_gap();
        do_reset();
        send(4'h5, 4'hA, 1'b1);
        repeat (13) tick();
        checks++;
        if (bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL gap_idle got valid=%b, want 0", bus.valid_o);
        end
        send(4'hC, 4'h3, 1'b1);
        repeat (3) tick();
        checks++;
        if ({bus.valid_o, bus.taddr_o, bus.last_o} !== {1'b1, 2'd2, 1'b1}) begin
            failures++;
            $display("FAIL gap_last got valid=%b taddr=%0d last=%b, want 1 2 1",
                     bus.valid_o, bus.taddr_o, bus.last_o);
        end
        tick();
        check_drained("gap");
    endtask

    initial begin
        reset        = 1'b0;
        bus.strobe_i = 1'b0;
        bus.idata_i  = '0;
        bus.qdata_i  = '0;
        checks       = 0;
        failures     = 0;
        exp_scnt     = 0;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_stream();
        test_overflow();
        test_boundary();
        test_reset_mid();
        test_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sigstream
`default_nettype wire

// File: doc/sigstream.md
SIGSTREAM -- requirements
Module: sigstream

Interface
REQ-001 SHALL have parameter WIDTH, default 32: number of antennas/signals.
REQ-002 SHALL have parameter TRATE, default 30: time-multiplexing rate, i.e. replays per antenna sample.
REQ-003 SHALL have parameter TBITS, default 5: taddr width; TRATE <= 2**TBITS.
REQ-004 SHALL have parameter COUNT, default 64: antenna samples per correlation window.
REQ-005 SHALL have parameter CBITS, default 6: window-counter width; COUNT <= 2**CBITS.
REQ-006 Ports SHALL be as follows; one clock; reset is asynchronous and active-high.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- strobe_i  in  1  single-cycle pulse: new antenna sample present on idata_i/qdata_i.
- idata_i  in  WIDTH  in-phase bit per antenna.
- qdata_i  in  WIDTH  quadrature bit per antenna.
- valid_o  out  1  stream beat valid.
- first_o  out  1  first beat of a correlation window.
- last_o  out  1  last beat of a correlation window.
- taddr_o  out  TBITS  time-slot address, 0..TRATE-1.
- idata_o  out  WIDTH  replayed I sample.
- qdata_o  out  WIDTH  replayed Q sample.
- overflow_o  out  1  sticky sample-drop flag.

Function
REQ-007 SHALL hold a two-entry buffer: a pending register with a full flag, and an active register driving idata_o/qdata_o.
REQ-008 On strobe_i=1 with pending empty, or with pending being consumed in the same cycle, SHALL capture idata_i/qdata_i into pending and set full.
REQ-009 On strobe_i=1 with pending full and not consumed that cycle, SHALL drop the new sample, keep the old one, and set overflow_o=1 until reset.
REQ-010 SHALL implement FSM IDLE/PLAY; IDLE->PLAY when pending is full: pending moves to active, taddr_o=0, valid_o=1 on the next edge, full cleared.
REQ-011 In PLAY, taddr_o SHALL increment by 1 per cycle with valid_o=1 held continuously.
REQ-012 At taddr_o=TRATE-1 with pending full, SHALL load the next sample back-to-back: taddr_o wraps to 0, no valid_o gap.
REQ-013 At taddr_o=TRATE-1 with pending empty, SHALL return to IDLE with valid_o=0 on the next cycle.
REQ-014 Latency: strobe_i sampled at edge k SHALL give the first beat (taddr_o=0) registered at edge k+1 when IDLE.
REQ-015 SHALL count replayed samples in window counter scnt, 0..COUNT-1, incrementing at each taddr_o=TRATE-1 beat and wrapping to 0 after COUNT-1.
REQ-016 first_o SHALL equal valid_o & (taddr_o==0) & (scnt==0); last_o SHALL equal valid_o & (taddr_o==TRATE-1) & (scnt==COUNT-1).
REQ-017 scnt SHALL hold across IDLE gaps, so a window may span gaps; valid_o=0 beats SHALL never assert first_o/last_o.
REQ-018 All outputs SHALL be registered; idata_o/qdata_o SHALL be stable for all TRATE beats of one sample.
REQ-019 Strobe period >= TRATE cycles SHALL never set overflow_o.

Reset
REQ-020 Asserting reset SHALL immediately set valid_o=0, first_o=0, last_o=0, taddr_o=0, overflow_o=0, idata_o=0, qdata_o=0, scnt=0, full=0, FSM=IDLE.
REQ-021 Reset mid-window SHALL abandon the partial window; the first beat after release SHALL assert first_o.
REQ-022 strobe_i SHALL be ignored while reset is asserted.

Structure
REQ-023 Shared package sigstream_pkg SHALL hold the default WIDTH/TRATE/TBITS/COUNT/CBITS constants and the IDLE/PLAY state encoding, reused by sigsource instances.
REQ-024 The taddr/scnt counter pair SHALL be one sub-module, tcounter, with wrap and terminal-count outputs; all else stays inline.

Verification (bench: WIDTH=4, TRATE=3, COUNT=2)
REQ-025 Single strobe, I=4'hA, Q=4'h5 -> three beats, taddr 0,1,2; data A/5 on each; first_o on beat 0; valid_o low afterwards.
REQ-026 Strobes every 3 cycles, 4 samples -> 12 contiguous valid beats; first_o at beats 0 and 6; last_o at beats 5 and 11; overflow_o=0.
REQ-027 Three strobes on consecutive cycles -> samples 1 and 2 replayed, sample 3 dropped, overflow_o=1 from the third strobe onward.
REQ-028 Strobe in the same cycle as taddr_o=2 with pending empty -> captured, no overflow, and the new sample starts at taddr 0 after at most one idle cycle.
REQ-029 Reset pulse at beat 4 of a window -> outputs zero asynchronously; the next strobe yields first_o=1 at taddr 0.
REQ-030 Two samples separated by a 10-cycle gap -> last_o asserted at the second sample's taddr 2 (window spans the gap).
